// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the main-memory responder on the common snoop bus.
package mem_resp_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_REQ,
      RD_DRIVE,
      WR_WAIT,
      WR_DONE
   } mem_state_t;

   // A never-written word reads back as its own word-aligned address.
   function automatic logic [63:0] unwrittenPattern(input logic [63:0] addr);
      return {addr[63:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word storage with per-word valid bits: one synchronous write port and one
// asynchronous read port that substitutes the address pattern for unwritten words.
module mem_resp_array
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wrEn_i,
   input  logic [DEPTH_LOG2-1:0] wrIdx_i,
   input  logic [DATA_W-1:0]     wrData_i,
   input  logic [ADDR_W-1:0]     rdAddr_i,
   output logic [DATA_W-1:0]     rdData_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [DEPTH-1:0]      valid_q;
   logic [DEPTH_LOG2-1:0] rdIdx;
   logic [DATA_W-1:0]     patWord;

   assign rdIdx   = rdAddr_i[DEPTH_LOG2+1:2];
   assign patWord = DATA_W'(unwrittenPattern(64'(rdAddr_i)));

   always_ff @(posedge clk) begin
      if (wrEn_i) begin
         mem_q[wrIdx_i] <= wrData_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wrEn_i) begin
         valid_q[wrIdx_i] <= 1'b1;
      end
   end

   assign rdData_o = valid_q[rdIdx] ? mem_q[rdIdx] : patWord;

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory end of the snoop bus: serves BusRd/BusRdX after a fixed latency once the
// arbiter grants the bus, and commits Mem_wr write-backs after a fixed latency.
module main_memory_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DEPTH_LOG2 = 10,
   parameter int RD_LATENCY = 4,
   parameter int WR_LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] Address_Com,
   inout  wire  [DATA_W-1:0] Data_Bus_Com,
   input  logic              BusRd,
   input  logic              BusRdX,
   input  logic              Mem_wr,
   input  logic              Mem_oprn_abort,
   input  logic              Mem_snoop_gnt,
   output logic              Mem_snoop_req,
   output logic              Data_in_Bus,
   output logic              Mem_write_done
);

   localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   mem_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              memWrEn;
   logic              busOe;
   logic              rdReq;
   logic [DATA_W-1:0] rdData;

   assign rdReq = BusRd | BusRdX;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // The counter only advances while waiting out a latency and restarts on any state change.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      memWrEn = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Mem_wr) begin
               addr_d  = Address_Com;
               wdata_d = Data_Bus_Com;
               state_d = WR_WAIT;
            end else if (rdReq) begin
               addr_d  = Address_Com;
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (Mem_oprn_abort) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
               state_d = RD_REQ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RD_REQ: begin
            if (Mem_oprn_abort) begin
               state_d = IDLE;
            end else if (Mem_snoop_gnt) begin
               state_d = RD_DRIVE;
            end
         end
         RD_DRIVE: begin
            if (!rdReq) begin
               state_d = IDLE;
            end
         end
         WR_WAIT: begin
            if (cnt_q == CNT_W'(WR_LATENCY - 1)) begin
               memWrEn = 1'b1;
               state_d = WR_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WR_DONE: begin
            if (!Mem_wr) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Mem_snoop_req  = (state_q == RD_REQ) || (state_q == RD_DRIVE);
      Data_in_Bus    = (state_q == RD_DRIVE);
      Mem_write_done = (state_q == WR_DONE);
      busOe          = (state_q == RD_DRIVE);
   end

   mem_resp_array #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .wrEn_i   (memWrEn),
      .wrIdx_i  (addr_q[DEPTH_LOG2+1:2]),
      .wrData_i (wdata_q),
      .rdAddr_i (addr_q),
      .rdData_o (rdData)
   );

   assign Data_Bus_Com = busOe ? rdData : {DATA_W{1'bz}};

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder: directed vector table, hand-written
// corner sequences, then random transactions against a word-level memory model.
module tb_main_memory_responder;

   localparam int RD_LAT = 4;
   localparam int WR_LAT = 4;

   logic        clk;
   logic        rst;
   logic [31:0] addrCom;
   logic        busRd;
   logic        busRdX;
   logic        memWr;
   logic        abortReq;
   logic        snoopGnt;
   logic        snoopReq;
   logic        dataInBus;
   logic        writeDone;
   logic        tbDrive;
   logic [31:0] tbData;
   wire  [31:0] dataBus;

   int checks;
   int passes;

   // Reference memory: word index -> last written data; absent means never written.
   logic [31:0] model [int];

   typedef struct {
      bit          isWrite;
      logic [31:0] addr;
      logic [31:0] data;
      int          gntDelay;
      int          rdKind;
      logic [31:0] expData;
      string       name;
   } vec_t;

   vec_t vecs [7];

   for (genvar b = 0; b < 32; b++) begin : gPull
      pulldown (dataBus[b]);
   end
   assign dataBus = tbDrive ? tbData : 32'hzzzz_zzzz;

   main_memory_responder #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .DEPTH_LOG2 (10),
      .RD_LATENCY (RD_LAT),
      .WR_LATENCY (WR_LAT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .Address_Com    (addrCom),
      .Data_Bus_Com   (dataBus),
      .BusRd          (busRd),
      .BusRdX         (busRdX),
      .Mem_wr         (memWr),
      .Mem_oprn_abort (abortReq),
      .Mem_snoop_gnt  (snoopGnt),
      .Mem_snoop_req  (snoopReq),
      .Data_in_Bus    (dataInBus),
      .Mem_write_done (writeDone)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int wordIdx(input logic [31:0] a);
      return int'(a[11:2]);
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      if (model.exists(wordIdx(a))) return model[wordIdx(a)];
      return {a[31:2], 2'b00};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end else begin
         passes++;
      end
   endtask

   // Write-back: data held on the bus while Mem_wr is high; address/data scrambled after accept.
   task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input string name);
      int cycles;
      @(negedge clk);
      memWr   = 1'b1;
      addrCom = addr;
      tbDrive = 1'b1;
      tbData  = data;
      @(negedge clk);
      addrCom = ~addr;
      tbData  = ~data;
      cycles  = 1;
      while (!writeDone && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({name, " write latency"}, 64'(cycles), 64'(WR_LAT + 1));
      memWr   = 1'b0;
      tbDrive = 1'b0;
      model[wordIdx(addr)] = data;
      @(negedge clk);
   endtask

   // Read: rdKind 0=BusRd, 1=BusRdX, 2=both; grant raised gntDelay cycles after request seen.
   task automatic doRead(input logic [31:0] addr, input int gntDelay, input int rdKind,
                         input logic [31:0] expData, input string name);
      int cycles;
      bit steady;
      @(negedge clk);
      busRd   = (rdKind != 1);
      busRdX  = (rdKind != 0);
      addrCom = addr;
      @(negedge clk);
      addrCom = addr ^ 32'hffff_f000;
      cycles  = 1;
      while (!snoopReq && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({name, " req latency"}, 64'(cycles), 64'(RD_LAT + 1));
      steady = (dataInBus == 1'b0) && (dataBus === 32'h0);
      for (int i = 0; i < gntDelay; i++) begin
         @(negedge clk);
         if (!snoopReq || dataInBus || (dataBus !== 32'h0)) steady = 1'b0;
      end
      checkOutput({name, " wait for grant"}, 64'(steady), 64'd1);
      snoopGnt = 1'b1;
      @(negedge clk);
      checkOutput({name, " drive"}, {31'd0, snoopReq, dataInBus, dataBus}, {31'd0, 2'b11, expData});
      snoopGnt = 1'b0;
      busRd    = 1'b0;
      busRdX   = 1'b0;
      @(negedge clk);
      checkOutput({name, " release"}, {snoopReq, dataInBus, dataBus}, 34'd0);
   endtask

   task automatic applyStimulus(input vec_t v);
      if (v.isWrite) doWrite(v.addr, v.data, v.name);
      else           doRead(v.addr, v.gntDelay, v.rdKind, v.expData, v.name);
   endtask

   initial begin
      int          cycles;
      bit          bad;
      logic [31:0] a;
      logic [31:0] d;

      checks   = 0;
      passes   = 0;
      rst      = 1'b1;
      addrCom  = '0;
      busRd    = 1'b0;
      busRdX   = 1'b0;
      memWr    = 1'b0;
      abortReq = 1'b0;
      snoopGnt = 1'b0;
      tbDrive  = 1'b0;
      tbData   = '0;

      vecs[0] = '{1'b0, 32'hdeadbeef, 32'h0,        2, 0, 32'hdeadbeec, "rd miss deadbeef"};
      vecs[1] = '{1'b1, 32'hbabecafe, 32'hcafecafe, 0, 0, 32'h0,        "wr babecafe"};
      vecs[2] = '{1'b0, 32'hbabecafe, 32'h0,        0, 1, 32'hcafecafe, "rdx after wr"};
      vecs[3] = '{1'b0, 32'h00000ff3, 32'h0,        1, 2, 32'h00000ff0, "rd both miss ff3"};
      vecs[4] = '{1'b1, 32'h00000ff0, 32'h12345678, 0, 0, 32'h0,        "wr ff0"};
      vecs[5] = '{1'b0, 32'h00001ff0, 32'h0,        3, 0, 32'h12345678, "rd alias 1ff0"};
      vecs[6] = '{1'b0, 32'hfffffffc, 32'h0,        0, 0, 32'hfffffffc, "rd top miss"};

      repeat (2) @(negedge clk);
      checkOutput("reset outputs", {snoopReq, dataInBus, writeDone, dataBus}, 35'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle outputs", {snoopReq, dataInBus, writeDone, dataBus}, 35'd0);

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

      // Abort during the read latency: memory must never request the bus.
      @(negedge clk);
      busRd   = 1'b1;
      addrCom = 32'h4;
      bad     = 1'b0;
      @(negedge clk);
      if (snoopReq || dataInBus || (dataBus !== 32'h0)) bad = 1'b1;
      @(negedge clk);
      abortReq = 1'b1;
      busRd    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         abortReq = 1'b0;
         if (snoopReq || dataInBus || (dataBus !== 32'h0)) bad = 1'b1;
      end
      checkOutput("abort never drives", 64'(bad), 64'd0);
      doRead(32'h4, 0, 0, 32'h4, "rd after abort");

      // Write and read presented together: write first, read accepted after the idle gap.
      // 0x10004 and 0x50004 share a word index, so the read sees the written word.
      @(negedge clk);
      memWr   = 1'b1;
      busRd   = 1'b1;
      addrCom = 32'h00010004;
      tbDrive = 1'b1;
      tbData  = 32'hcafecafb;
      @(negedge clk);
      addrCom = 32'h00050004;
      cycles  = 1;
      while (!writeDone && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("simul write latency", 64'(cycles), 64'(WR_LAT + 1));
      checkOutput("simul read waits", 64'(snoopReq), 64'd0);
      memWr   = 1'b0;
      tbDrive = 1'b0;
      model[wordIdx(32'h00010004)] = 32'hcafecafb;
      cycles = 0;
      while (!snoopReq && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("simul read req latency", 64'(cycles), 64'(RD_LAT + 2));
      snoopGnt = 1'b1;
      @(negedge clk);
      checkOutput("simul read data", {dataInBus, dataBus}, {1'b1, modelRead(32'h00050004)});
      snoopGnt = 1'b0;
      busRd    = 1'b0;
      @(negedge clk);

      doRead(32'h00001230, 20, 0, 32'h00001230, "gnt withheld");

      // Reset while driving: outputs and bus drop without waiting for a clock edge.
      @(negedge clk);
      busRd   = 1'b1;
      addrCom = 32'hbabecafe;
      cycles  = 0;
      while (!snoopReq && cycles < 60) begin
         @(negedge clk);
         cycles++;
      end
      snoopGnt = 1'b1;
      @(negedge clk);
      snoopGnt = 1'b0;
      checkOutput("pre-reset drive", {dataInBus, dataBus}, {1'b1, 32'hcafecafe});
      #2 rst = 1'b1;
      #1;
      checkOutput("async reset outputs", {snoopReq, dataInBus, writeDone, dataBus}, 35'd0);
      busRd = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model.delete();
      doRead(32'hbabecafe, 1, 0, 32'hbabecafc, "post-reset read");

      for (int t = 0; t < 40; t++) begin
         a = {20'($urandom_range(0, 3)), 10'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 2) == 0) begin
            d = $urandom;
            doWrite(a, d, $sformatf("rand wr %0d", t));
         end else begin
            doRead(a, $urandom_range(0, 4), $urandom_range(0, 2), modelRead(a),
                   $sformatf("rand rd %0d", t));
         end
      end

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
